iter_div_unit: RTL
==================

Name: iter_div_unit

Overview:
- Parametrised multi-cycle integer divider for the execute stage; successor to the fixed 32-bit divider.
- Adds configurable operand width and bits resolved per cycle.
- Adds early-out for divide-by-zero and |dividend| < |divisor|, an explicit busy flag, and defined divide-by-zero and signed-overflow results.
- Uses the execute stage's existing handshake: en = is_div & ~done, stall-hold on done, flush abort.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and ≥ 8.
- BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; legal values 1, 2, 4, and it must divide WIDTH.
- EARLY_OUT, 1, when 1, |dividend| < |divisor| completes without iterating.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- is_flush  in  1  abort the current operation; unit returns to IDLE.
- is_stall  in  1  downstream not ready; holds results in DONE.
- en  in  1  start request, sampled only in IDLE.
- is_signed  in  1  two's-complement division when 1.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- quotient  out  WIDTH  result quotient, valid while done=1.
- remainder  out  WIDTH  result remainder, valid while done=1.
- done  out  1  result valid.
- busy  out  1  state is CALC.
- div_by_zero  out  1  valid with done; divisor was 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; quotient, remainder, done, busy, div_by_zero all 0; iteration counter 0.
- Registered state machine with states IDLE, CALC, DONE. All outputs are registered or decoded from state (done = state==DONE, busy = state==CALC).
- IDLE, on en=1 & is_flush=0 (operands and is_signed latched this edge):
  - Record sign_q = is_signed & (sign(dividend) ^ sign(divisor)) and sign_r = is_signed & sign(dividend).
  - Take absolute values of both operands.
  - divisor==0: go to DONE. quotient = all ones, remainder = dividend (original bits), div_by_zero = 1.
  - else EARLY_OUT & |dividend| < |divisor|: go to DONE. quotient = 0, remainder = dividend (original bits).
  - else: go to CALC with counter = WIDTH/BITS_PER_CYCLE − 1 and partial remainder = 0.
- CALC: each cycle performs BITS_PER_CYCLE chained restoring shift-subtract steps (MSB first) into a WIDTH+1-bit partial remainder.
  - When counter==0, the next state is DONE. On that edge, apply sign fixups: negate quotient if sign_q, negate remainder if sign_r.
  - en, is_signed and operand inputs are ignored in CALC.
  - is_stall does not pause CALC.
- DONE:
  - done=1 and outputs are held stable.
  - is_stall=1: stay in DONE, with no limit on how long.
  - is_stall=0: go to IDLE next cycle, so done is high for exactly one cycle when not stalled. div_by_zero clears with done.
  - en in DONE is ignored. The upstream term ~done makes en low here anyway.
- is_flush=1 in any state: the next state is IDLE, and flush beats en, is_stall and completion in the same cycle. done/busy are low the following cycle. Partial results are discarded and no done pulse is produced.
- Latency, counting the en-accept edge as cycle 0:
  - Normal case: done is high in cycle WIDTH/BITS_PER_CYCLE + 1 (33 for 32/1; 17 for 32/2).
  - Divide-by-zero and early-out: done is high in cycle 1.
- Back-to-back: after DONE→IDLE, a new en is accepted in the IDLE cycle, giving at least one bubble between operations.
- Signed overflow (MIN / −1): quotient = MIN (WIDTH-bit wraparound of the negation), remainder = 0. No flag is raised.
- Sign convention: the quotient truncates toward zero; the remainder takes the sign of the dividend.
- Unsigned mode: operands are treated as WIDTH-bit unsigned values, with no sign fixup.
- Reset mid-operation: async to IDLE immediately, with outputs per the reset values.

Test Plan:
- Unsigned, WIDTH=32, BITS_PER_CYCLE=1, dividend=100, divisor=7, en pulsed at cycle 0 → busy in cycles 1–32; done=1 in cycle 33 with quotient=14, remainder=2; done=0 in cycle 34.
- Signed, dividend=0xFFFFFFF9 (−7), divisor=2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- Signed, dividend=0x80000000, divisor=0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divisor=0, dividend=0x1234 → done in cycle 1 with quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Early-out: unsigned 5/9 → done in cycle 1 with quotient=0, remainder=5.
- Stall hold: is_stall=1 when done first rises, held for 3 cycles → done and results stable for 4 cycles; done falls 1 cycle after is_stall drops.
- Flush abort: is_flush at cycle 10 of CALC → IDLE next cycle and done never asserts. A following en with 100/7 → correct result at full latency.
- Parameter sweep: WIDTH=32, BITS_PER_CYCLE=2 → done in cycle 17. WIDTH=16, BITS_PER_CYCLE=4 → done in cycle 5. Random signed/unsigned operands in both configurations match a reference model.

Source files
------------

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - parametrised multi-cycle restoring integer divider
module iter_div_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_flush,
  input  logic             is_stall,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;       // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_q, quo_d;       // |dividend| shifts out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // |divisor|
  logic             neg_q_q, neg_q_d;   // negate quotient at the end
  logic             neg_r_q, neg_r_d;   // negate remainder at the end
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_quo;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign abs_a = a_neg ? -dividend : dividend;
  assign abs_b = b_neg ? -divisor : divisor;

  // BITS_PER_CYCLE chained restoring shift-subtract steps, MSB first
  always_comb begin
    step_acc = acc_q;
    step_quo = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step_acc = {step_acc[WIDTH-1:0], step_quo[WIDTH-1]};
      step_quo = {step_quo[WIDTH-2:0], 1'b0};
      if (step_acc >= {1'b0, dvs_q}) begin
        step_acc    = step_acc - {1'b0, dvs_q};
        step_quo[0] = 1'b1;
      end
    end
  end

  // next-state and datapath updates; flush overrides everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          dvs_d   = abs_b;
          quo_d   = abs_a;
          acc_d   = '0;
          cnt_d   = CNT_W'(STEPS - 1);
          if (divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else if ((EARLY_OUT != 0) && (abs_a < abs_b)) begin
            state_d     = S_DONE;
            quotient_d  = '0;
            remainder_d = dividend;
            dbz_d       = 1'b0;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          quotient_d  = neg_q_q ? -step_quo : step_quo;
          remainder_d = neg_r_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end
      S_DONE: begin
        if (!is_stall) begin
          state_d = S_IDLE;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (is_flush) begin
      state_d     = S_IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q == S_CALC);

endmodule
